clap_counter_369: RTL and testbench
===================================

# clap_counter_369

Parametrised BCD counter for the 369 clap game, successor to the fixed 4-bit 3-6-9-13 sequence counter. It holds a DIGITS-digit decimal count and reports how many of its digits are 3, 6 or 9. It runs in one of two modes: plain increment, or a multi-cycle skip search that advances to the next number needing a clap. It sits in the lab datapath between the game controller (en/skip_mode/load) and the display/clap logic.

## Interface
- DIGITS, 2, number of BCD digits; ≥1; count range 0 … 10^DIGITS−1
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- en  in  1  advance request; honoured only while valid=1
- skip_mode  in  1  0 = step by one, 1 = search to next clap number; sampled with en
- load  in  1  synchronous load; highest priority after reset
- load_value  in  4*DIGITS  BCD value for load; any digit >9 is stored as 9
- count  out  4*DIGITS  current BCD value, digit i at bits [4i+3:4i]
- claps  out  $clog2(DIGITS+1)  combinational: number of digits of count equal to 3, 6 or 9
- hit  out  1  combinational: claps ≠ 0
- valid  out  1  1 = IDLE, count is a settled result; 0 = search in progress

## Operation
- One clock; reset is synchronous and active-low; clk and reset_n as named above.
- Registers: count, internal candidate cand (4*DIGITS), state ∈ {IDLE, SEARCH}.
- Priority per edge: reset_n=0 > load > state action.
- Reset: count=0, cand=0, state=IDLE → valid=1, claps=0, hit=0.
- load=1 (any state, aborts a search): count ← clamped load_value, state ← IDLE.
- IDLE, en=1, skip_mode=0: count ← count+1 (BCD, ripple carry per digit; all-9s wraps to 0).
- IDLE, en=1, skip_mode=1: cand ← count+1 (BCD, same wrap), state ← SEARCH.
- IDLE, en=0: hold.
- SEARCH, each edge: if cand contains a 3/6/9 digit → count ← cand, state ← IDLE; else cand ← cand+1 (BCD wrap).
- In SEARCH, en and skip_mode are ignored; count holds the previous result until commit.
- Search always terminates: value 3 is reached within at most 10^DIGITS candidates.
- claps/hit are pure functions of count, never of cand.

## Timing
- Step mode: count updates on the edge sampling en=1; latency 1 clock; valid stays 1.
- Skip mode: valid falls on the request edge; commit edge = request edge + N, where N = (target − count) mod 10^DIGITS; valid=1 from the commit edge onward.
- Examples (DIGITS=2): 0→3 N=3, valid high on edge 4 after request counting request as edge 1; 9→13 takes 5 edges; 99→3 (via 0,1,2,3) takes 5 edges.
- A new en is accepted on the commit edge's following edge at earliest (valid must be sampled 1).
- reset_n=0 mid-search: next edge yields count=0, valid=1; no commit of cand.
- load and en in the same cycle: load wins, en dropped.

## Test plan
- Reset: hold reset_n=0 two edges with en=1, load=1 → count=0, claps=0, hit=0, valid=1; release, no change without en.
- Step wrap (DIGITS=2): load 0x98, en=1, skip_mode=0 for 3 edges → count 0x99 (claps=2), 0x00, 0x01; valid never low.
- Skip sequence (DIGITS=2): from reset, repeated skip requests → count 0x03, 0x06, 0x09, 0x13, 0x16, 0x19, 0x23; valid low exactly 3,3,3,4,3,3,4 cycles respectively; 0x33 reports claps=2.
- Skip wrap: load 0x99, skip request → valid low 4 cycles, commit count=0x03; DIGITS=1 build: from 9, skip → 3.
- Abort: start skip from 0x09, assert reset_n=0 on second SEARCH cycle → count=0x00, valid=1; repeat with load=1, load_value=0x4F → count=0x49, claps=1, valid=1.
- Ignored inputs: during SEARCH toggle en and skip_mode every cycle → commit value and latency identical to undisturbed run.

Source files
------------

// File: rtl/clap_counter_369.sv
// clap_counter_369 -- DIGITS-digit BCD counter for the 369 clap game.
//
// Holds a decimal count and reports how many of its digits are 3, 6 or 9.
// Two advance modes: plain +1 step, or a multi-cycle search that walks an
// internal candidate forward one value per clock until it holds a 3/6/9
// digit, then commits it to count.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   en          advance request, honoured only while valid=1
//   skip_mode   0 = step by one, 1 = search to next clap number
//   load        synchronous load (wins over en, aborts a search)
//   load_value  BCD load value, digits above 9 stored as 9
//   count       current BCD value, digit i at [4i+3:4i]
//   claps       number of digits of count equal to 3, 6 or 9
//   hit         claps != 0
//   valid       1 = idle with a settled count, 0 = search in progress
module clap_counter_369 #(
    parameter int DIGITS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic                         skip_mode,
    input  logic                         load,
    input  logic [4*DIGITS-1:0]          load_value,
    output logic [4*DIGITS-1:0]          count,
    output logic [$clog2(DIGITS+1)-1:0]  claps,
    output logic                         hit,
    output logic                         valid
);

    localparam int CW = $clog2(DIGITS+1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t                   state;
    logic [DIGITS-1:0][3:0]   count_q;
    logic [DIGITS-1:0][3:0]   cand_q;
    logic [DIGITS-1:0][3:0]   load_clamp;
    logic [DIGITS-1:0][3:0]   inc_src;
    logic [DIGITS-1:0][3:0]   inc_val;
    logic [DIGITS-1:0]        src_clap;
    logic                     ripple;

    function automatic logic is_369(input logic [3:0] d);
        return (d == 4'd3) || (d == 4'd6) || (d == 4'd9);
    endfunction

    // Clamp each load digit into 0..9 so count never holds a non-BCD digit.
    always_comb begin
        load_clamp = '0;
        for (int i = 0; i < DIGITS; i++)
            load_clamp[i] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end

    // One shared BCD incrementer: count is the source while idle, cand while
    // searching. Its 3/6/9 flags therefore describe cand during SEARCH.
    assign inc_src = (state == SEARCH) ? cand_q : count_q;

    always_comb begin
        inc_val  = '0;
        src_clap = '0;
        ripple   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ripple)
                inc_val[i] = (inc_src[i] == 4'd9) ? 4'd0 : inc_src[i] + 4'd1;
            else
                inc_val[i] = inc_src[i];
            src_clap[i] = is_369(inc_src[i]);
            ripple      = ripple & (inc_src[i] == 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            cand_q  <= '0;
            state   <= IDLE;
        end else if (load) begin
            count_q <= load_clamp;
            state   <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (!skip_mode) begin
                            count_q <= inc_val;
                        end else begin
                            cand_q <= inc_val;
                            state  <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // Commit as soon as the candidate needs a clap; count
                    // keeps the previous result until then.
                    if (|src_clap) begin
                        count_q <= cand_q;
                        state   <= IDLE;
                    end else begin
                        cand_q <= inc_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        claps = '0;
        for (int i = 0; i < DIGITS; i++)
            if (is_369(count_q[i])) claps = claps + CW'(1);
    end

    assign count = count_q;
    assign hit   = |claps;
    assign valid = (state == IDLE);

endmodule

// File: tb/tb_clap_counter_369.sv
module tb_clap_counter_369;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0, skip_mode = 1'b0, load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [7:0] count;
    logic [1:0] claps;
    logic       hit, valid;

    logic       en1 = 1'b0, skip1 = 1'b0, load1 = 1'b0;
    logic [3:0] lv1 = 4'h0;
    logic [3:0] count1;
    logic       claps1, hit1, valid1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clap_counter_369 #(.DIGITS(2)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .skip_mode(skip_mode),
        .load(load), .load_value(load_value), .count(count),
        .claps(claps), .hit(hit), .valid(valid)
    );

    clap_counter_369 #(.DIGITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en1), .skip_mode(skip1),
        .load(load1), .load_value(lv1), .count(count1),
        .claps(claps1), .hit(hit1), .valid(valid1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: plain decimal integers ----
    function automatic int claps_of(input int v, input int nd);
        int n = 0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            if ((x % 10) == 3 || (x % 10) == 6 || (x % 10) == 9) n++;
            x = x / 10;
        end
        return n;
    endfunction

    function automatic int to_bcd(input int v, input int nd);
        int r = 0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r = r | ((x % 10) << (4*i));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamp(input int raw, input int nd);
        int r = 0;
        int w = 1;
        for (int i = 0; i < nd; i++) begin
            int d = (raw >> (4*i)) & 15;
            if (d > 9) d = 9;
            r = r + d * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic int next_clap(input int v, input int nd);
        int m = 10 ** nd;
        for (int k = 1; k <= m; k++)
            if (claps_of((v + k) % m, nd) != 0) return (v + k) % m;
        return v;
    endfunction

    // Model state: the count, and while a search is outstanding the target
    // and the number of edges left until it commits.
    int m2_cnt = 0, m2_rem = 0, m2_tgt = 0;
    bit m2_busy = 1'b0;
    int m1_cnt = 0, m1_rem = 0, m1_tgt = 0;
    bit m1_busy = 1'b0;

    always begin
        @(posedge clk);
        if (!reset_n) begin
            m2_cnt = 0; m2_busy = 1'b0;
        end else if (load) begin
            m2_cnt = from_bcd_clamp(int'(load_value), 2); m2_busy = 1'b0;
        end else if (!m2_busy) begin
            if (en) begin
                if (!skip_mode) m2_cnt = (m2_cnt + 1) % 100;
                else begin
                    m2_tgt  = next_clap(m2_cnt, 2);
                    m2_rem  = (m2_tgt - m2_cnt + 100) % 100;
                    m2_busy = 1'b1;
                end
            end
        end else begin
            m2_rem--;
            if (m2_rem == 0) begin m2_cnt = m2_tgt; m2_busy = 1'b0; end
        end

        if (!reset_n) begin
            m1_cnt = 0; m1_busy = 1'b0;
        end else if (load1) begin
            m1_cnt = from_bcd_clamp(int'(lv1), 1); m1_busy = 1'b0;
        end else if (!m1_busy) begin
            if (en1) begin
                if (!skip1) m1_cnt = (m1_cnt + 1) % 10;
                else begin
                    m1_tgt  = next_clap(m1_cnt, 1);
                    m1_rem  = (m1_tgt - m1_cnt + 10) % 10;
                    m1_busy = 1'b1;
                end
            end
        end else begin
            m1_rem--;
            if (m1_rem == 0) begin m1_cnt = m1_tgt; m1_busy = 1'b0; end
        end

        #1;
        chk("m2_count", int'(count), to_bcd(m2_cnt, 2));
        chk("m2_claps", int'(claps), claps_of(m2_cnt, 2));
        chk("m2_hit",   int'(hit),   int'(claps_of(m2_cnt, 2) != 0));
        chk("m2_valid", int'(valid), int'(!m2_busy));
        chk("m1_count", int'(count1), to_bcd(m1_cnt, 1));
        chk("m1_claps", int'(claps1), claps_of(m1_cnt, 1));
        chk("m1_hit",   int'(hit1),   int'(claps_of(m1_cnt, 1) != 0));
        chk("m1_valid", int'(valid1), int'(!m1_busy));
    end

    // ---- directed stimulus; every task starts and ends just after a negedge ----
    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic skip_req(input bit tog, output int low);
        en = 1'b1; skip_mode = 1'b1;
        @(negedge clk);
        en = 1'b0; skip_mode = 1'b0;
        low = 0;
        while (!valid && low < 200) begin
            low++;
            if (tog) begin en = ~en; skip_mode = ~skip_mode; end
            @(negedge clk);
        end
        en = 1'b0; skip_mode = 1'b0;
    endtask

    initial begin
        int low;
        int exp_v[7]   = '{'h03, 'h06, 'h09, 'h13, 'h16, 'h19, 'h23};
        int exp_low[7] = '{3, 3, 3, 4, 3, 3, 4};
        int exp_step[3] = '{'h99, 'h00, 'h01};

        en = 1'b1; load = 1'b1; load_value = 8'h55; reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_claps", int'(claps), 0);
        chk("rst_hit",   int'(hit),   0);
        chk("rst_valid", int'(valid), 1);
        reset_n = 1'b1; en = 1'b0; load = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", int'(count), 0);

        for (int i = 0; i < 7; i++) begin
            skip_req(1'b0, low);
            chk("skip_low", low, exp_low[i]);
            chk("skip_val", int'(count), exp_v[i]);
        end

        do_load(8'h33);
        chk("claps_33", int'(claps), 2);
        chk("hit_33",   int'(hit),   1);

        do_load(8'h98);
        en = 1'b1; skip_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("step_val",   int'(count), exp_step[i]);
            chk("step_valid", int'(valid), 1);
        end
        chk("claps_01", int'(claps), 0);
        en = 1'b0;

        do_load(8'h99);
        skip_req(1'b0, low);
        chk("wrap_low", low, 4);
        chk("wrap_val", int'(count), 'h03);

        load1 = 1'b1; lv1 = 4'h9;
        @(negedge clk);
        load1 = 1'b0;
        chk("d1_load", int'(count1), 9);
        en1 = 1'b1; skip1 = 1'b1;
        @(negedge clk);
        en1 = 1'b0; skip1 = 1'b0;
        low = 0;
        while (!valid1 && low < 100) begin low++; @(negedge clk); end
        chk("d1_low", low, 4);
        chk("d1_val", int'(count1), 3);

        do_load(8'h09);
        en = 1'b1; skip_mode = 1'b1;
        @(negedge clk);
        en = 1'b0; skip_mode = 1'b0;
        chk("abort_busy", int'(valid), 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_rst_val",   int'(count), 0);
        chk("abort_rst_valid", int'(valid), 1);

        do_load(8'h09);
        en = 1'b1; skip_mode = 1'b1;
        @(negedge clk);
        en = 1'b0; skip_mode = 1'b0;
        @(negedge clk);
        do_load(8'h4F);
        chk("abort_ld_val",   int'(count), 'h49);
        chk("abort_ld_claps", int'(claps), 1);
        chk("abort_ld_valid", int'(valid), 1);

        do_load(8'h09);
        skip_req(1'b1, low);
        chk("ignore_low", low, 4);
        chk("ignore_val", int'(count), 'h13);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: finished=0, required=1");
        $fatal(1, "watchdog expired");
    end

endmodule
